pc_update_ctrl: RTL and testbench

Sequencer that drives the select and write-enable of the PC-source multiplexer in the multicycle datapath. Accepts one PC-update request per instruction from the main control unit (sequential, branch, jump, jump-register, return-from-exception) and runs the multi-cycle exception-entry sequence: save EPC, fetch the handler byte from the vector address, load PC. It sits between the main control FSM and the PC/EPC registers, the PC-source mux and the memory address mux.

---
 rtl/pc_update_ctrl_if.sv | 31 +++
 rtl/pc_update_ctrl.sv | 145 ++++++++++++++
 tb/tb_pc_update_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pc_update_ctrl_if.sv
// PC-update handshake and PC/EPC/memory control bundle between main control,
// the PC-update sequencer and the datapath muxes.
interface pc_update_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_kind;
  logic       branch_cond;
  logic       exc_opcode;
  logic       exc_overflow;
  logic       exc_div0;
  logic [2:0] pc_source;
  logic       pc_write;
  logic       epc_write;
  logic       alu_pc_minus4;
  logic       mem_read_exc;
  logic [1:0] exc_addr_sel;
  logic [1:0] exc_cause;
  logic       done;

  modport master (
    output req_valid, req_kind, branch_cond, exc_opcode, exc_overflow, exc_div0,
    input  req_ready, pc_source, pc_write, epc_write, alu_pc_minus4, mem_read_exc,
    input  exc_addr_sel, exc_cause, done
  );

  modport slave (
    input  req_valid, req_kind, branch_cond, exc_opcode, exc_overflow, exc_div0,
    output req_ready, pc_source, pc_write, epc_write, alu_pc_minus4, mem_read_exc,
    output exc_addr_sel, exc_cause, done
  );
endinterface

// File: rtl/pc_update_ctrl.sv
// PC-source sequencer: one-cycle PC updates plus the multi-cycle exception entry
// (save EPC, read vector byte, load PC). All outputs are registered.
module pc_update_ctrl #(
  parameter int unsigned MemWait = 1
) (
  input logic              clk,
  input logic              rst_n,
  pc_update_ctrl_if.slave  ctrl_io
);

  typedef enum logic [2:0] {StIdle, StUpdate, StExcSave, StExcRead, StExcLoad} state_e;

  localparam logic [2:0] KindSeq    = 3'd0;
  localparam logic [2:0] KindBranch = 3'd1;
  localparam logic [2:0] KindJump   = 3'd2;
  localparam logic [2:0] KindJr     = 3'd3;
  localparam logic [2:0] KindRte    = 3'd4;
  localparam logic [2:0] ReadLast   = 3'(MemWait - 1);

  state_e     state_q;
  logic [2:0] cnt_q;
  logic [1:0] exc_cause_q, exc_cause_d;
  logic       req_ready_q;
  logic [2:0] pc_source_q;
  logic       pc_write_q;
  logic       epc_write_q;
  logic       alu_pc_minus4_q;
  logic       mem_read_exc_q;
  logic [1:0] exc_addr_sel_q;
  logic       done_q;
  logic [2:0] upd_src;
  logic       upd_pw;

  // Zero means no exception; an illegal kind on a valid request becomes an opcode fault.
  always_comb begin
    exc_cause_d = 2'd0;
    if (ctrl_io.exc_opcode) begin
      exc_cause_d = 2'd1;
    end else if (ctrl_io.exc_overflow) begin
      exc_cause_d = 2'd2;
    end else if (ctrl_io.exc_div0) begin
      exc_cause_d = 2'd3;
    end else if (ctrl_io.req_valid && (ctrl_io.req_kind > KindRte)) begin
      exc_cause_d = 2'd1;
    end
  end

  always_comb begin
    upd_src = 3'd4;
    upd_pw  = 1'b1;
    case (ctrl_io.req_kind)
      KindSeq:    upd_src = 3'd1;
      KindBranch: begin
        upd_src = 3'd3;
        upd_pw  = ctrl_io.branch_cond;
      end
      KindJump:   upd_src = 3'd2;
      KindJr:     upd_src = 3'd0;
      default:    upd_src = 3'd4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      cnt_q           <= 3'd0;
      exc_cause_q     <= 2'd0;
      req_ready_q     <= 1'b1;
      pc_source_q     <= 3'd0;
      pc_write_q      <= 1'b0;
      epc_write_q     <= 1'b0;
      alu_pc_minus4_q <= 1'b0;
      mem_read_exc_q  <= 1'b0;
      exc_addr_sel_q  <= 2'd0;
      done_q          <= 1'b0;
    end else begin
      req_ready_q     <= 1'b0;
      pc_source_q     <= 3'd0;
      pc_write_q      <= 1'b0;
      epc_write_q     <= 1'b0;
      alu_pc_minus4_q <= 1'b0;
      mem_read_exc_q  <= 1'b0;
      exc_addr_sel_q  <= 2'd0;
      done_q          <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (exc_cause_d != 2'd0) begin
            state_q         <= StExcSave;
            exc_cause_q     <= exc_cause_d;
            epc_write_q     <= 1'b1;
            alu_pc_minus4_q <= 1'b1;
          end else if (ctrl_io.req_valid) begin
            state_q     <= StUpdate;
            pc_source_q <= upd_src;
            pc_write_q  <= upd_pw;
            done_q      <= 1'b1;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        StUpdate: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
        end
        StExcSave: begin
          state_q        <= StExcRead;
          cnt_q          <= ReadLast;
          mem_read_exc_q <= 1'b1;
          exc_addr_sel_q <= exc_cause_q;
        end
        StExcRead: begin
          exc_addr_sel_q <= exc_cause_q;
          if (cnt_q == 3'd0) begin
            state_q     <= StExcLoad;
            pc_source_q <= 3'd5;
            pc_write_q  <= 1'b1;
            done_q      <= 1'b1;
          end else begin
            cnt_q          <= cnt_q - 3'd1;
            mem_read_exc_q <= 1'b1;
          end
        end
        StExcLoad: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ctrl_io.req_ready     = req_ready_q;
  assign ctrl_io.pc_source     = pc_source_q;
  assign ctrl_io.pc_write      = pc_write_q;
  assign ctrl_io.epc_write     = epc_write_q;
  assign ctrl_io.alu_pc_minus4 = alu_pc_minus4_q;
  assign ctrl_io.mem_read_exc  = mem_read_exc_q;
  assign ctrl_io.exc_addr_sel  = exc_addr_sel_q;
  assign ctrl_io.exc_cause     = exc_cause_q;
  assign ctrl_io.done          = done_q;

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Bench for pc_update_ctrl: two instances (memory wait 1 and 3) share one stimulus
// stream, each compared against a schedule-based reference model.
module tb_pc_update_ctrl;

  localparam int unsigned Mw0 = 1;
  localparam int unsigned Mw1 = 3;

  logic clk;
  logic rst_n;

  pc_update_ctrl_if if0 ();
  pc_update_ctrl_if if1 ();

  pc_update_ctrl #(.MemWait(Mw0)) u_dut0 (.clk(clk), .rst_n(rst_n), .ctrl_io(if0.slave));
  pc_update_ctrl #(.MemWait(Mw1)) u_dut1 (.clk(clk), .rst_n(rst_n), .ctrl_io(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Frame layout: {ready, src[2:0], pc_wr, epc_wr, pc_m4, mem_rd, sel[1:0], cause[1:0], done}
  logic [12:0] obs [2];
  always_comb begin
    obs[0] = {if0.req_ready, if0.pc_source, if0.pc_write, if0.epc_write, if0.alu_pc_minus4,
              if0.mem_read_exc, if0.exc_addr_sel, if0.exc_cause, if0.done};
    obs[1] = {if1.req_ready, if1.pc_source, if1.pc_write, if1.epc_write, if1.alu_pc_minus4,
              if1.mem_read_exc, if1.exc_addr_sel, if1.exc_cause, if1.done};
  end

  // Reference model: on acceptance, the whole future output sequence is queued.
  logic [12:0] cur [2];
  logic [12:0] sched [2][16];
  int          len [2];
  int          pos [2];
  logic [1:0]  cause_m [2];

  function automatic logic [12:0] frame(input logic rdy, input logic [2:0] src, input logic pw,
                                        input logic ew, input logic m4, input logic mr,
                                        input logic [1:0] sel, input logic [1:0] c,
                                        input logic dn);
    return {rdy, src, pw, ew, m4, mr, sel, c, dn};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      cause_m[d] = 2'd0;
      len[d]     = 0;
      pos[d]     = 0;
      cur[d]     = frame(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    end
  endtask

  task automatic check(input string tag);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      assert (obs[d] === cur[d]) else begin
        miscompares++;
        $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs[d], cur[d]);
      end
    end
  endtask

  task automatic drive_step(input logic v, input logic [2:0] k, input logic bc,
                            input logic eo, input logic eov, input logic ed);
    int          mw;
    logic [1:0]  c;
    logic [2:0]  src;
    logic        pw;
    if0.req_valid = v;  if0.req_kind = k;  if0.branch_cond = bc;
    if0.exc_opcode = eo; if0.exc_overflow = eov; if0.exc_div0 = ed;
    if1.req_valid = v;  if1.req_kind = k;  if1.branch_cond = bc;
    if1.exc_opcode = eo; if1.exc_overflow = eov; if1.exc_div0 = ed;
    for (int d = 0; d < 2; d++) begin
      mw = (d == 0) ? Mw0 : Mw1;
      if (cur[d][12]) begin
        c = eo ? 2'd1 : eov ? 2'd2 : ed ? 2'd3 : (v && k > 3'd4) ? 2'd1 : 2'd0;
        len[d] = 0;
        pos[d] = 0;
        if (c != 2'd0) begin
          cause_m[d] = c;
          sched[d][len[d]++] = frame(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, c, 1'b0);
          for (int i = 0; i < mw; i++)
            sched[d][len[d]++] = frame(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, c, c, 1'b0);
          sched[d][len[d]++] = frame(1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, c, c, 1'b1);
        end else if (v) begin
          pw = 1'b1;
          case (k)
            3'd0: src = 3'd1;
            3'd1: begin src = 3'd3; pw = bc; end
            3'd2: src = 3'd2;
            3'd3: src = 3'd0;
            default: src = 3'd4;
          endcase
          sched[d][len[d]++] = frame(1'b0, src, pw, 1'b0, 1'b0, 1'b0, 2'd0, cause_m[d], 1'b1);
        end
      end
      if (pos[d] < len[d]) cur[d] = sched[d][pos[d]++];
      else cur[d] = frame(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, cause_m[d], 1'b0);
    end
  endtask

  task automatic cycle(input string tag, input logic v, input logic [2:0] k, input logic bc,
                       input logic eo, input logic eov, input logic ed);
    @(negedge clk);
    check(tag);
    drive_step(v, k, bc, eo, eov, ed);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] rk;
    rst_n = 1'b0;
    if0.req_valid = 1'b0; if0.req_kind = 3'd0; if0.branch_cond = 1'b0;
    if0.exc_opcode = 1'b0; if0.exc_overflow = 1'b0; if0.exc_div0 = 1'b0;
    if1.req_valid = 1'b0; if1.req_kind = 3'd0; if1.branch_cond = 1'b0;
    if1.exc_opcode = 1'b0; if1.exc_overflow = 1'b0; if1.exc_div0 = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset");
    rst_n = 1'b1;
    drive_step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // SEQ then JR back to back
    cycle("seq_req", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("seq_upd", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("jr_req",  1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("jr_upd",  1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Branch not taken, then taken
    cycle("br_nt_req", 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("br_nt_upd", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("br_t_req",  1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("br_t_upd",  1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Overflow exception
    cycle("ovf_req", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cycles("ovf_seq", 7);

    // Simultaneous div0, overflow and JUMP; opcode pulse during read is ignored
    cycle("sim_req", 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle("sim_save", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("sim_read", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_cycles("sim_seq", 6);

    // Illegal kind becomes an opcode exception
    cycle("ill_req", 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycles("ill_seq", 7);

    // Asynchronous reset in the middle of the vector read
    cycle("rst_exc", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("rst_save", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_pre");
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_async");
    @(negedge clk);
    check("rst_hold");
    rst_n = 1'b1;
    drive_step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rk = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      cycle("rand", 1'($urandom_range(0, 1)), rk, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 11) == 0),
            1'($urandom_range(0, 11) == 0));
    end
    @(negedge clk);
    check("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
